// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions used by the fetch and decode stages and by the
// hazard and forwarding blocks.
package pipeline_pkg;

  localparam int          XLEN_DEF  = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN_DEF-1:0] pc;
    logic [XLEN_DEF-1:0] instr;
    logic                valid;
  } if_id_t;

endpackage

// File: rtl/pc_reg.sv
// Program counter register. Priority from highest to lowest: reset, flush
// redirect (word aligned), advance by one instruction, hold.
module pc_reg
  import pipeline_pkg::*;
#(
  parameter int          XLEN     = XLEN_DEF,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            pc_write,
  input  logic [XLEN-1:0] branch_target,
  output logic [XLEN-1:0] pc
);

  logic [XLEN-1:0] pc_r;

  // PC update; the add wraps naturally at the top of the address space
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_r <= RESET_PC;
    end else if (flush) begin
      pc_r <= {branch_target[XLEN-1:2], 2'b00};
    end else if (pc_write) begin
      pc_r <= pc_r + XLEN'(4);
    end else begin
      pc_r <= pc_r;
    end
  end

  assign pc = pc_r;

endmodule

// File: rtl/if_stage.sv
// Fetch stage: owns the PC, addresses instruction memory and holds the IF/ID
// pipeline register plus saturating stall and flush event counters.
module if_stage
  import pipeline_pkg::*;
#(
  parameter int              XLEN     = XLEN_DEF,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter int              CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pc_write,
  input  logic             if_id_write,
  input  logic             flush,
  input  logic [XLEN-1:0]  branch_target,
  output logic [XLEN-1:0]  imem_addr,
  input  logic [XLEN-1:0]  imem_rdata,
  output logic [XLEN-1:0]  if_id_pc,
  output logic [XLEN-1:0]  if_id_instr,
  output logic             if_id_valid,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [XLEN-1:0]  pc_s;
  logic [XLEN-1:0]  if_id_pc_r;
  logic [XLEN-1:0]  if_id_instr_r;
  logic             if_id_valid_r;
  logic [CNT_W-1:0] stall_count_r;
  logic [CNT_W-1:0] flush_count_r;
  logic             stall_event_s;

  pc_reg #(
    .XLEN     (XLEN),
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk           (clk),
    .rst           (rst),
    .flush         (flush),
    .pc_write      (pc_write),
    .branch_target (branch_target),
    .pc            (pc_s)
  );

  assign imem_addr     = pc_s;
  // A stall cycle is one where the PC is frozen and no redirect is pending
  assign stall_event_s = !flush && !pc_write;

  // IF/ID register: a flush squashes even while the register is held
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      if_id_pc_r    <= '0;
      if_id_instr_r <= XLEN'(NOP_INSTR);
      if_id_valid_r <= 1'b0;
    end else if (if_id_write) begin
      if_id_pc_r    <= pc_s;
      if_id_instr_r <= imem_rdata;
      if_id_valid_r <= 1'b1;
    end else begin
      if_id_pc_r    <= if_id_pc_r;
      if_id_instr_r <= if_id_instr_r;
      if_id_valid_r <= if_id_valid_r;
    end
  end

  // Saturating event counters, cleared only by reset
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_count_r <= '0;
      flush_count_r <= '0;
    end else begin
      if (stall_event_s && (stall_count_r != CNT_MAX)) begin
        stall_count_r <= stall_count_r + CNT_W'(1);
      end else begin
        stall_count_r <= stall_count_r;
      end
      if (flush && (flush_count_r != CNT_MAX)) begin
        flush_count_r <= flush_count_r + CNT_W'(1);
      end else begin
        flush_count_r <= flush_count_r;
      end
    end
  end

  assign if_id_pc    = if_id_pc_r;
  assign if_id_instr = if_id_instr_r;
  assign if_id_valid = if_id_valid_r;
  assign stall_count = stall_count_r;
  assign flush_count = flush_count_r;

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed scenarios followed by random
// control sequences, all compared against a cycle-level reference model.
module tb_if_stage;

  localparam int          XLEN  = 32;
  localparam int          CNT_W = 4;
  localparam int          CNT_MAX_I = (1 << CNT_W) - 1;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic             clk;
  logic             rst;
  logic             pc_write;
  logic             if_id_write;
  logic             flush;
  logic [XLEN-1:0]  branch_target;
  logic [XLEN-1:0]  imem_addr;
  logic [XLEN-1:0]  imem_rdata;
  logic [XLEN-1:0]  if_id_pc;
  logic [XLEN-1:0]  if_id_instr;
  logic             if_id_valid;
  logic [CNT_W-1:0] stall_count;
  logic [CNT_W-1:0] flush_count;

  int n_checks;
  int n_fail;

  // reference model state
  logic [31:0] m_pc;
  logic [31:0] m_ifid_pc;
  logic [31:0] m_ifid_instr;
  logic        m_ifid_valid;
  int          m_stall;
  int          m_flush;

  if_stage #(
    .XLEN     (XLEN),
    .RESET_PC (32'h0000_0000),
    .CNT_W    (CNT_W)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .pc_write      (pc_write),
    .if_id_write   (if_id_write),
    .flush         (flush),
    .branch_target (branch_target),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .if_id_pc      (if_id_pc),
    .if_id_instr   (if_id_instr),
    .if_id_valid   (if_id_valid),
    .stall_count   (stall_count),
    .flush_count   (flush_count)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    return 32'hAAAA_0000 | addr;
  endfunction

  assign imem_rdata = mem_word(imem_addr);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check_eq({tag, ".imem_addr"},   imem_addr,   m_pc);
    check_eq({tag, ".if_id_pc"},    if_id_pc,    m_ifid_pc);
    check_eq({tag, ".if_id_instr"}, if_id_instr, m_ifid_instr);
    check_eq({tag, ".if_id_valid"}, 32'(if_id_valid), 32'(m_ifid_valid));
    check_eq({tag, ".stall_count"}, 32'(stall_count), 32'(m_stall));
    check_eq({tag, ".flush_count"}, 32'(flush_count), 32'(m_flush));
  endtask

  // one clock cycle with the given controls, model update, then full compare
  task automatic step(input string tag, input logic r, input logic pw, input logic iw,
                      input logic fl, input logic [31:0] tgt);
    logic [31:0] pc_before;
    rst = r; pc_write = pw; if_id_write = iw; flush = fl; branch_target = tgt;
    @(posedge clk);
    pc_before = m_pc;
    if (r) begin
      m_pc = 32'h0; m_ifid_pc = 32'h0; m_ifid_instr = NOP; m_ifid_valid = 1'b0;
      m_stall = 0; m_flush = 0;
    end else begin
      if (fl) m_pc = tgt & 32'hFFFF_FFFC;
      else if (pw) m_pc = pc_before + 32'd4;
      if (fl) begin
        m_ifid_pc = 32'h0; m_ifid_instr = NOP; m_ifid_valid = 1'b0;
      end else if (iw) begin
        m_ifid_pc = pc_before; m_ifid_instr = mem_word(pc_before); m_ifid_valid = 1'b1;
      end
      if (fl) m_flush = (m_flush < CNT_MAX_I) ? m_flush + 1 : m_flush;
      else if (!pw) m_stall = (m_stall < CNT_MAX_I) ? m_stall + 1 : m_stall;
    end
    #1;
    check_all(tag);
    @(negedge clk);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1; pc_write = 1'b0; if_id_write = 1'b0; flush = 1'b0; branch_target = '0;
    @(negedge clk);

    // 1: reset then free run
    step("t1_rst0", 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    step("t1_rst1", 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    check_eq("t1_addr0", imem_addr, 32'h0);
    step("t1_run0", 1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    check_eq("t1_ifid_instr0", if_id_instr, 32'hAAAA_0000);
    step("t1_run1", 1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    check_eq("t1_addr8", imem_addr, 32'h8);
    check_eq("t1_ifid_pc4", if_id_pc, 32'h4);

    // 2: one-cycle load-use stall at pc=8
    step("t2_stall", 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    check_eq("t2_addr_hold", imem_addr, 32'h8);
    check_eq("t2_stall_cnt", 32'(stall_count), 32'd1);
    step("t2_resume", 1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    check_eq("t2_addr12", imem_addr, 32'hC);
    step("t2_run", 1'b0, 1'b1, 1'b1, 1'b0, 32'h0);

    // 3: flush at pc=16 with unaligned target
    step("t3_flush", 1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_0103);
    check_eq("t3_addr", imem_addr, 32'h100);
    check_eq("t3_instr_nop", if_id_instr, 32'h13);
    step("t3_after", 1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    check_eq("t3_ifid_pc", if_id_pc, 32'h100);
    check_eq("t3_valid", 32'(if_id_valid), 32'd1);

    // 4: flush during stall
    step("t4_flush_stall", 1'b0, 1'b0, 1'b0, 1'b1, 32'h200);
    check_eq("t4_addr", imem_addr, 32'h200);
    check_eq("t4_stall_cnt", 32'(stall_count), 32'd1);
    check_eq("t4_flush_cnt", 32'(flush_count), 32'd2);

    // 5: PC wrap and stall counter saturation
    step("t5_preload", 1'b0, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFFC);
    step("t5_wrap", 1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    check_eq("t5_addr_wrap", imem_addr, 32'h0);
    for (int i = 0; i < 20; i++) step("t5_sat", 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    check_eq("t5_stall_sat", 32'(stall_count), 32'd15);

    // 6: reset mid-stall and mid-flush
    step("t6_rst", 1'b1, 1'b0, 1'b1, 1'b1, 32'h300);
    check_eq("t6_addr", imem_addr, 32'h0);
    check_eq("t6_stall", 32'(stall_count), 32'd0);

    // random control sequences
    for (int i = 0; i < 400; i++) begin
      logic r, pw, iw, fl;
      logic [31:0] tgt;
      r   = ($urandom_range(0, 59) == 0);
      fl  = ($urandom_range(0, 6) == 0);
      pw  = ($urandom_range(0, 3) != 0);
      iw  = ($urandom_range(0, 3) != 0);
      tgt = $urandom();
      step("rnd", r, pw, iw, fl, tgt);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
Fetch stage plus IF/ID pipeline register. It consumes the stall controls produced by hazard_detection (PCWrite, IF/ID write) and the branch flush from EX. It owns the PC, drives the instruction-memory address, and presents a registered PC, instruction and valid bit to ID. Stall and flush events are counted for performance visibility.

Parameters:
XLEN, 32, data/address width
RESET_PC, 32'h0000_0000, PC value after reset
CNT_W, 16, width of saturating event counters

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous reset, active-high
pc_write  input  1  1 = advance PC; 0 = hold (load-use stall)
if_id_write  input  1  1 = load IF/ID register; 0 = hold
flush  input  1  branch taken in EX; redirect PC and squash IF/ID
branch_target  input  XLEN  redirect address, valid when flush=1
imem_addr  output  XLEN  instruction-memory address (combinational = PC)
imem_rdata  input  XLEN  instruction word for imem_addr, combinational read
if_id_pc  output  XLEN  PC of instruction held in IF/ID
if_id_instr  output  XLEN  instruction held in IF/ID
if_id_valid  output  1  1 = IF/ID holds a real instruction
stall_count  output  CNT_W  cycles with pc_write=0 and flush=0, saturating
flush_count  output  CNT_W  cycles with flush=1, saturating

Behaviour:
- One clock domain; clk and rst only. Reset is synchronous, active-high. All state updates on the rising edge of clk.
- Reset values:
  - pc = RESET_PC
  - if_id_pc = 0
  - if_id_instr = NOP (32'h0000_0013)
  - if_id_valid = 0
  - stall_count = 0
  - flush_count = 0
- rst takes priority over every other input in the same cycle. Reset asserted mid-stall or mid-flush discards that event.
- imem_addr = pc at all times, combinationally.
- PC update, in priority order:
  - flush=1: pc <= {branch_target[XLEN-1:2], 2'b00}. Low bits are forced to zero and pc_write is ignored.
  - else pc_write=1: pc <= pc + 4, wrapping modulo 2^XLEN (32'hFFFF_FFFC -> 0).
  - else: pc holds.
- IF/ID update, in priority order:
  - flush=1: if_id_instr <= NOP, if_id_pc <= 0, if_id_valid <= 0. Flush overrides if_id_write=0, so the squash happens during a stall.
  - else if_id_write=1: if_id_pc <= pc, if_id_instr <= imem_rdata, if_id_valid <= 1.
  - else: all IF/ID fields hold their values.
- Latency: the instruction at PC appears on the IF/ID outputs 1 cycle after it is addressed. A redirect takes 1 cycle: the cycle after flush, imem_addr = target and if_id_valid = 0. The target instruction is valid one cycle later.
- pc_write and if_id_write are independent; the mismatched combinations are legal:
  - pc_write=1, if_id_write=0: PC advances and IF/ID holds. The skipped fetch is lost; that is the caller's responsibility.
  - pc_write=0, if_id_write=1: IF/ID re-latches the same PC and instruction.
- Counters:
  - stall_count increments when !flush && !pc_write.
  - flush_count increments when flush.
  - Both saturate at 2^CNT_W-1 and do not wrap. Both clear only on rst.
- No X propagation: outputs are defined from the first post-reset edge.

Decomposition:
- pipeline_pkg:
  - XLEN_DEF = 32
  - NOP_INSTR = 32'h0000_0013
  - if_id_t packed struct {pc, instr, valid}, shared with the ID stage and the hazard/forwarding blocks.
- Sub-module pc_reg: holds the PC with reset, flush-redirect, advance and hold priority; outputs the current PC.
- The IF/ID register and the counters stay in if_stage.

Test Plan:
1. Reset then free run. rst=1 for 2 cycles; pc_write=if_id_write=1, imem_rdata = 32'hAAAA_0000 | addr. Required: imem_addr sequence is 0, 4, 8, 12. One cycle after each address, if_id_pc equals that address, if_id_instr = 32'hAAAA_0000 | addr and if_id_valid = 1. Both counters stay 0.
2. Load-use stall. At pc=8, drive pc_write=if_id_write=0 for 1 cycle. Required: imem_addr stays 8 for 2 cycles. IF/ID holds if_id_pc=4. stall_count = 1. Fetch resumes at 12 afterwards.
3. Flush. At pc=16, flush=1 and branch_target=32'h0000_0103. Required next cycle: imem_addr=32'h100, if_id_valid=0, if_id_instr=32'h13, flush_count=1. The cycle after: if_id_pc=32'h100 and if_id_valid=1.
4. Flush during stall. Drive flush=1, pc_write=0, if_id_write=0 with target 32'h200. Required: pc=32'h200, IF/ID squashed, stall_count unchanged, flush_count +1.
5. Wrap and saturation.
   - Preload pc=32'hFFFF_FFFC via flush. Required: the next advance gives imem_addr=0.
   - With CNT_W=4, hold pc_write=0 for 20 cycles. Required: stall_count = 15.
6. Reset mid-stall. Assert rst while pc_write=0 and flush=1. Required next cycle: pc=RESET_PC, if_id_valid=0, both counters 0.
